// File: rtl/pe_operand_collector.sv
// Operand collector ahead of the PE functional unit: one-entry A and B slots,
// B source selection (stream / constant / accumulator feedback) and a stall counter.
module pe_operand_collector #(
  parameter int N_BITS      = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   flush_i,
  input  logic [N_BITS-1:0]      a_i,
  input  logic                   a_valid_i,
  output logic                   a_ready_o,
  input  logic [N_BITS-1:0]      b_i,
  input  logic                   b_valid_i,
  output logic                   b_ready_o,
  input  logic                   b_sel_const_i,
  input  logic [N_BITS-1:0]      const_i,
  input  logic                   acc_loopback_i,
  input  logic [N_BITS-1:0]      fb_i,
  input  logic                   fu_ready_i,
  output logic [N_BITS-1:0]      a_o,
  output logic [N_BITS-1:0]      b_o,
  output logic                   ops_valid_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high. Upstream readies depend combinationally on fu_ready_i so a slot can be
  // drained and refilled in the same cycle; ops_valid_o never depends on *_valid_i.

  logic                   a_full_q, a_full_d;
  logic [N_BITS-1:0]      a_data_q, a_data_d;
  logic                   b_full_q, b_full_d;
  logic [N_BITS-1:0]      b_data_q, b_data_d;
  logic [N_BITS-1:0]      acc_q, acc_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic b_avail;
  logic b_from_slot;
  logic fire;
  logic a_consume;
  logic b_consume;
  logic stall;

  always_comb begin
    b_from_slot = !b_sel_const_i && !acc_loopback_i;
    b_avail     = b_sel_const_i || acc_loopback_i || b_full_q;
    ops_valid_o = a_full_q && b_avail;
    fire        = ops_valid_o && fu_ready_i;
    stall       = ops_valid_o && !fu_ready_i;
    a_consume   = fire;
    b_consume   = fire && b_from_slot;
    a_ready_o   = !a_full_q || a_consume;
    b_ready_o   = !b_full_q || b_consume;
    a_o         = a_data_q;
    if (b_sel_const_i) begin
      b_o = const_i;
    end else if (acc_loopback_i) begin
      b_o = acc_q;
    end else begin
      b_o = b_data_q;
    end
    stall_cnt_o = stall_q;
  end

  always_comb begin
    a_full_d = a_full_q;
    a_data_d = a_data_q;
    b_full_d = b_full_q;
    b_data_d = b_data_q;
    acc_d    = acc_q;
    stall_d  = stall_q;
    if (flush_i) begin
      a_full_d = 1'b0;
      a_data_d = '0;
      b_full_d = 1'b0;
      b_data_d = '0;
      acc_d    = '0;
      stall_d  = '0;
    end else begin
      if (a_valid_i && a_ready_o) begin
        a_full_d = 1'b1;
        a_data_d = a_i;
      end else if (a_consume) begin
        a_full_d = 1'b0;
      end
      if (b_valid_i && b_ready_o) begin
        b_full_d = 1'b1;
        b_data_d = b_i;
      end else if (b_consume) begin
        b_full_d = 1'b0;
      end
      if (fire) begin
        acc_d = fb_i;
      end
      // Saturate rather than wrap so long DIV stalls never read as a small count.
      if (stall && (stall_q != {STALL_CNT_W{1'b1}})) begin
        stall_d = stall_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_full_q <= 1'b0;
      a_data_q <= '0;
      b_full_q <= 1'b0;
      b_data_q <= '0;
      acc_q    <= '0;
      stall_q  <= '0;
    end else begin
      a_full_q <= a_full_d;
      a_data_q <= a_data_d;
      b_full_q <= b_full_d;
      b_data_q <= b_data_d;
      acc_q    <= acc_d;
      stall_q  <= stall_d;
    end
  end

endmodule

// File: tb/tb_pe_operand_collector.sv
// Bench for pe_operand_collector: directed scenarios plus random traffic, with a
// queue-based reference model checked by a negedge monitor.
module tb_pe_operand_collector;
  localparam int W  = 32;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [W-1:0]  a_in = '0;
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic [W-1:0]  b_in = '0;
  logic          b_valid = 1'b0;
  logic          b_ready;
  logic          sel_const = 1'b0;
  logic [W-1:0]  const_v = '0;
  logic          loopback = 1'b0;
  logic [W-1:0]  fb;
  logic          fu_ready = 1'b1;
  logic [W-1:0]  a_out;
  logic [W-1:0]  b_out;
  logic          ops_valid;
  logic [SW-1:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  pe_operand_collector #(.N_BITS(W), .STALL_CNT_W(SW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .a_i(a_in), .a_valid_i(a_valid), .a_ready_o(a_ready),
    .b_i(b_in), .b_valid_i(b_valid), .b_ready_o(b_ready),
    .b_sel_const_i(sel_const), .const_i(const_v),
    .acc_loopback_i(loopback), .fb_i(fb), .fu_ready_i(fu_ready),
    .a_o(a_out), .b_o(b_out), .ops_valid_o(ops_valid), .stall_cnt_o(stall_cnt)
  );

  // The FU is modelled as an adder: its result feeds back to the collector.
  assign fb = a_out + b_out;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model + monitor ----------------
  logic [W-1:0]  a_q[$];
  logic [W-1:0]  b_q[$];
  logic [W-1:0]  acc_m = '0;
  logic [SW-1:0] stall_m = '0;

  always @(negedge clk) begin
    logic exp_valid, take_b, exp_fire, exp_a_rdy, exp_b_rdy;
    logic [W-1:0] ea, eb;
    if (!rst_n) begin
      a_q.delete(); b_q.delete(); acc_m = '0; stall_m = '0;
    end else begin
      take_b    = !sel_const && !loopback;
      exp_valid = (a_q.size() > 0) && (!take_b || b_q.size() > 0);
      exp_fire  = exp_valid && fu_ready;
      exp_a_rdy = (a_q.size() == 0) || exp_fire;
      exp_b_rdy = (b_q.size() == 0) || (exp_fire && take_b);
      check("ops_valid", W'(ops_valid), W'(exp_valid));
      check("a_ready", W'(a_ready), W'(exp_a_rdy));
      check("b_ready", W'(b_ready), W'(exp_b_rdy));
      check("stall_cnt", W'(stall_cnt), W'(stall_m));
      if (flush) begin
        a_q.delete(); b_q.delete(); acc_m = '0; stall_m = '0;
      end else begin
        if (exp_valid && !fu_ready && stall_m != '1) stall_m = stall_m + 1'b1;
        if (exp_fire) begin
          ea = a_q.pop_front();
          if (sel_const)     eb = const_v;
          else if (loopback) eb = acc_m;
          else               eb = b_q.pop_front();
          check("pair_a", a_out, ea);
          check("pair_b", b_out, eb);
          acc_m = ea + eb;
        end
        if (a_valid && exp_a_rdy) a_q.push_back(a_in);
        if (b_valid && exp_b_rdy) b_q.push_back(b_in);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; b_valid = 1'b0; flush = 1'b0;
    sel_const = 1'b0; loopback = 1'b0; fu_ready = 1'b1;
  endtask

  task automatic do_flush();
    next_cycle();
    idle_inputs();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
  endtask

  initial begin
    // reset state, with the constant selected to see it on b_o
    sel_const = 1'b1; const_v = 32'd55;
    #3;
    check("rst_ops_valid", W'(ops_valid), 0);
    check("rst_a_ready", W'(a_ready), 1);
    check("rst_b_ready", W'(b_ready), 1);
    check("rst_stall", W'(stall_cnt), 0);
    check("rst_a_o", a_out, 0);
    check("rst_b_o_const", b_out, 55);
    sel_const = 1'b0;
    #1;
    check("rst_b_o", b_out, 0);
    next_cycle();
    rst_n = 1'b1;

    // streaming 5,6,7 / 1,2,3
    next_cycle();
    a_in = 5; b_in = 1; a_valid = 1; b_valid = 1;
    #3 check("stream_no_valid_yet", W'(ops_valid), 0);
    next_cycle(); a_in = 6; b_in = 2;
    #3 check("stream_pair1_a", a_out, 5);
    check("stream_pair1_b", b_out, 1);
    check("stream_a_ready", W'(a_ready), 1);
    next_cycle(); a_in = 7; b_in = 3;
    #3 check("stream_pair2_a", a_out, 6);
    next_cycle(); idle_inputs();
    #3 check("stream_pair3_b", b_out, 3);
    next_cycle();
    #3 check("stream_drained", W'(ops_valid), 0);

    // backpressure on pair (10,20)
    do_flush();
    a_in = 10; b_in = 20; a_valid = 1; b_valid = 1; fu_ready = 0;
    next_cycle(); a_valid = 0; b_valid = 0;
    for (int i = 0; i < 4; i++) begin
      #3 check("bp_a_o_held", a_out, 10);
      check("bp_b_o_held", b_out, 20);
      check("bp_a_ready_low", W'(a_ready), 0);
      next_cycle();
    end
    fu_ready = 1;
    #3 check("bp_stall_4", W'(stall_cnt), 4);
    next_cycle();
    #3 check("bp_single_fire", W'(ops_valid), 0);

    // skewed arrival: A=9 at cycle 0, B=4 at cycle 3
    do_flush();
    a_in = 9; a_valid = 1;
    for (int c = 1; c <= 3; c++) begin
      next_cycle(); a_valid = 0;
      if (c == 3) begin b_in = 4; b_valid = 1; end
      #3 check("skew_a_ready_low", W'(a_ready), 0);
      check("skew_not_valid", W'(ops_valid), 0);
    end
    next_cycle(); b_valid = 0;
    #3 check("skew_valid", W'(ops_valid), 1);
    check("skew_b", b_out, 4);

    // constant mode
    do_flush();
    sel_const = 1; const_v = 100; a_in = 1; a_valid = 1;
    next_cycle(); a_in = 2;
    #3 check("const_b1", b_out, 100);
    next_cycle(); a_valid = 0;
    #3 check("const_a2", a_out, 2);
    check("const_b_slot_empty", W'(b_ready), 1);
    next_cycle(); sel_const = 0;

    // accumulation: B=0 then loopback, A=1,2,3 -> b_o 0,1,3
    do_flush();
    a_in = 1; a_valid = 1; b_in = 0; b_valid = 1;
    next_cycle(); a_in = 2; b_valid = 0;
    #3 check("acc_b0", b_out, 0);
    next_cycle(); a_in = 3; loopback = 1;
    #3 check("acc_b1", b_out, 1);
    next_cycle(); a_valid = 0;
    #3 check("acc_b3", b_out, 3);
    check("acc_b_slot_once", W'(b_ready), 1);
    next_cycle(); loopback = 0;

    // flush mid-operation
    do_flush();
    a_in = 7; a_valid = 1;
    next_cycle(); a_valid = 0; loopback = 1; fu_ready = 0;
    next_cycle(); loopback = 0; fu_ready = 1; flush = 1;
    #3 check("flush_pre_stall", W'(stall_cnt), 1);
    next_cycle(); flush = 0;
    #3 check("flush_valid", W'(ops_valid), 0);
    check("flush_a_ready", W'(a_ready), 1);
    check("flush_stall", W'(stall_cnt), 0);

    // asynchronous reset mid-operation
    a_in = 7; a_valid = 1;
    next_cycle(); a_valid = 0; loopback = 1; fu_ready = 0;
    next_cycle();
    #1 rst_n = 1'b0;
    #1 check("arst_valid", W'(ops_valid), 0);
    check("arst_a_ready", W'(a_ready), 1);
    check("arst_stall", W'(stall_cnt), 0);
    idle_inputs();
    next_cycle();
    rst_n = 1'b1;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      next_cycle();
      a_in      = $urandom;
      b_in      = $urandom;
      const_v   = $urandom_range(0, 1000);
      a_valid   = ($urandom_range(0, 99) < 60);
      b_valid   = ($urandom_range(0, 99) < 60);
      fu_ready  = ($urandom_range(0, 99) < 70);
      sel_const = ($urandom_range(0, 99) < 10);
      loopback  = ($urandom_range(0, 99) < 15);
      flush     = ($urandom_range(0, 99) < 2);
    end
    next_cycle();
    idle_inputs();
    for (int i = 0; i < 5; i++) next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pe_operand_collector.md
# pe_operand_collector

Operand-collection stage sitting directly upstream of the PE functional-unit wrapper. It buffers the A and B operand streams arriving from the PE input network in one-entry slots and selects B from the stream, a configured constant, or the registered accumulation feedback. It presents an aligned operand pair with `ops_valid_o` to the FU, honours the FU `ready_o` backpressure (for example, multi-cycle DIV), and exposes per-operand ready signals upstream.

## Interface
- `N_BITS`, 32 (from `pea_pkg`): operand/result width.
- `STALL_CNT_W`, 16: width of the stall performance counter.

- `clk_i`  in  1  clock
- `rst_n_i`  in  1  asynchronous active-low reset
- `flush_i`  in  1  synchronous clear of slots, feedback register and counter (reconfiguration)
- `a_i`  in  N_BITS  operand A data
- `a_valid_i`  in  1  operand A valid
- `a_ready_o`  out  1  operand A slot can accept
- `b_i`  in  N_BITS  operand B data
- `b_valid_i`  in  1  operand B valid
- `b_ready_o`  out  1  operand B slot can accept
- `b_sel_const_i`  in  1  1: B = `const_i`, B stream ignored
- `const_i`  in  N_BITS  configured constant operand
- `acc_loopback_i`  in  1  from FU `acc_loopback_o`; 1: B = feedback register
- `fb_i`  in  N_BITS  FU `res_o` (combinational result of the issued pair)
- `fu_ready_i`  in  1  FU `ready_o`
- `a_o`  out  N_BITS  operand A to FU
- `b_o`  out  N_BITS  operand B to FU
- `ops_valid_o`  out  1  operand pair valid to FU
- `stall_cnt_o`  out  STALL_CNT_W  saturating count of stalled cycles

## Operation
- State per slot: a full flag and a data register. A and B slots are independent.
- `b_avail` = `b_sel_const_i` OR `acc_loopback_i` OR `b_full`.
- `ops_valid_o` = `a_full` AND `b_avail`.
- `fire` = `ops_valid_o` AND `fu_ready_i`.
- B mux, in priority order:
  - `b_sel_const_i` → `const_i`
  - else `acc_loopback_i` → `acc_q`
  - else → B slot data
- `a_o` = A slot data.
- Slot consumption on fire:
  - The A slot is always consumed.
  - The B slot is consumed only when B was taken from the slot. It is not consumed when constant or loopback was selected.
- Ready rule: `x_ready_o` = NOT `x_full` OR `x_consumed`. Simultaneous consume and refill is allowed, giving 1 pair/cycle throughput.
- Capture: when `x_valid_i` AND `x_ready_o`, the slot loads data and sets full. Otherwise, on consume, it clears full.
- Feedback register: `acc_q` <= `fb_i` on every fire. It holds otherwise.
- Stall counter: increments when `ops_valid_o` AND NOT `fu_ready_i`, and saturates at all-ones.
- `flush_i` has priority over all updates. It clears the full flags, `acc_q` and the counter, and ignores same-cycle inputs.
- Reset values:
  - full flags 0; slot data 0; `acc_q` 0; `stall_cnt_o` 0
  - `ops_valid_o` 0; `a_o`/`b_o` 0 (or `const_i` if selected)
  - `a_ready_o`/`b_ready_o` 1
- Reset mid-operation discards buffered operands without issuing them.

## Timing
- Latency: an operand accepted at edge k is visible on `a_o`/`b_o` in cycle k+1, with `ops_valid_o` high in k+1 if its partner is available.
- No combinational path from `a_valid_i`/`b_valid_i` to `ops_valid_o`.
- Combinational paths:
  - `fu_ready_i` → `a_ready_o`/`b_ready_o`
  - `acc_loopback_i`/`b_sel_const_i` → `ops_valid_o`, `b_o`
  - `fb_i` reaches only the `acc_q` D-input.
- Backpressure: while `fu_ready_i`=0, `a_o`, `b_o` and `ops_valid_o` are held stable and slots do not change. This covers multi-cycle DIV with `ready_o` low.
- Unequal arrival: A arriving 3 cycles before B holds the A slot full, with `a_ready_o`=0 until the pair fires.

## Test plan
- Reset then streaming: A=5,6,7 and B=1,2,3 valid every cycle, `fu_ready_i`=1 → pairs (5,1),(6,2),(7,3) on consecutive cycles starting one cycle after first accept; readies stay 1.
- Backpressure: pair (10,20) presented, `fu_ready_i`=0 for 4 cycles → outputs stable, `a_ready_o`=`b_ready_o`=0, `stall_cnt_o`=4, single fire when ready returns.
- Skewed arrival: A=9 at cycle 0, B=4 at cycle 3 → `ops_valid_o` first high at cycle 4 with (9,4); `a_ready_o` low in cycles 1-3.
- Constant mode: `b_sel_const_i`=1, `const_i`=100, A=1,2 with `b_valid_i`=0 → pairs (1,100),(2,100); B slot stays empty.
- Accumulation: B=0 first; `acc_loopback_i`=1 afterwards with `fb_i`=A+B, and A=1,2,3 → `b_o` sequence 0,1,3; B slot consumed only once.
- Flush/reset mid-operation: A slot full (A=7), assert `flush_i` → next cycle `ops_valid_o`=0, `a_ready_o`=1, `stall_cnt_o`=0. Repeat with `rst_n_i` low asynchronously → same values immediately.
